// File: rtl/fp_alu_checker_if.sv
// Vector-in and mismatch-readout handshakes of fp_alu_checker.
// The source/reader side is the master; the harness is the slave.
interface fp_alu_checker_if #(parameter int CNT_W = 16);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_para1;
  logic [31:0]       in_para2;
  logic [1:0]        in_op;
  logic [31:0]       in_exp_out;
  logic              in_exp_uo;
  logic              rd_valid;
  logic              rd_ready;
  logic [CNT_W-1:0]  rd_index;
  logic [1:0]        rd_op;
  logic [31:0]       rd_out;
  logic              rd_uo;

  modport master (
    output in_valid, in_para1, in_para2, in_op, in_exp_out, in_exp_uo, rd_ready,
    input  in_ready, rd_valid, rd_index, rd_op, rd_out, rd_uo
  );
  modport slave (
    input  in_valid, in_para1, in_para2, in_op, in_exp_out, in_exp_uo, rd_ready,
    output in_ready, rd_valid, rd_index, rd_op, rd_out, rd_uo
  );
endinterface

// File: rtl/fp_alu_checker.sv
// Self-checking harness: registers vectors into FP_ALU, compares, counts,
// and queues mismatch records. FP_ALU: op 0 add, 1 sub, 2 mul, 3 pass para1.
module FP_ALU (
  input  logic [31:0] para1,
  input  logic [31:0] para2,
  input  logic [1:0]  ALU_op,
  output logic [31:0] out,
  output logic        zero,
  output logic        under_overflow
);
  localparam logic [1:0] OP_SUB = 2'd1, OP_MUL = 2'd2, OP_MOV = 2'd3;
  logic [23:0] m1, m2, m_hi, m_lo, m_sh;
  logic [7:0]  e_hi, e_lo, d;
  logic        sb, s_hi, s_lo, swap, rs, is_zero;
  logic [24:0] s, s_n;
  logic [47:0] p;
  logic [22:0] frac;
  int          e, lz;

  // Truncating arithmetic, denormal inputs flushed to zero, no NaN/Inf special-casing.
  always_comb begin
    m1   = (para1[30:23] == 8'd0) ? 24'd0 : {1'b1, para1[22:0]};
    m2   = (para2[30:23] == 8'd0) ? 24'd0 : {1'b1, para2[22:0]};
    sb   = para2[31] ^ (ALU_op == OP_SUB);
    swap = para2[30:0] > para1[30:0];
    e_hi = swap ? para2[30:23] : para1[30:23];
    e_lo = swap ? para1[30:23] : para2[30:23];
    m_hi = swap ? m2 : m1;
    m_lo = swap ? m1 : m2;
    s_hi = swap ? sb : para1[31];
    s_lo = swap ? para1[31] : sb;
    d    = e_hi - e_lo;
    m_sh = (d > 8'd23) ? 24'd0 : (m_lo >> d);
    p    = m1 * m2;
    s    = '0;
    s_n  = '0;
    lz   = 0;
    frac = '0;
    e    = 0;
    rs   = s_hi;
    is_zero = 1'b0;
    if (ALU_op == OP_MUL) begin
      rs      = para1[31] ^ para2[31];
      is_zero = (m1 == 24'd0) || (m2 == 24'd0);
      if (p[47]) begin
        frac = p[46:24];
        e    = int'(para1[30:23]) + int'(para2[30:23]) - 126;
      end else begin
        frac = p[45:23];
        e    = int'(para1[30:23]) + int'(para2[30:23]) - 127;
      end
    end else if (s_hi == s_lo) begin
      s       = {1'b0, m_hi} + {1'b0, m_sh};
      is_zero = (s == 25'd0);
      if (s[24]) begin
        frac = s[23:1];
        e    = int'(e_hi) + 1;
      end else begin
        frac = s[22:0];
        e    = int'(e_hi);
      end
    end else begin
      s       = {1'b0, m_hi} - {1'b0, m_sh};
      is_zero = (s == 25'd0);
      lz      = 23;
      for (int i = 0; i <= 23; i++)
        if (s[i]) lz = 23 - i;
      s_n  = s << lz;
      frac = s_n[22:0];
      e    = int'(e_hi) - lz;
    end

    under_overflow = 1'b0;
    if (ALU_op == OP_MOV) out = para1;
    else if (is_zero)     out = {(ALU_op == OP_MUL) & rs, 31'd0};
    else if (e >= 255) begin
      out = {rs, 8'hFF, 23'd0};
      under_overflow = 1'b1;
    end else if (e <= 0) begin
      out = {rs, 31'd0};
      under_overflow = 1'b1;
    end else out = {rs, e[7:0], frac};
    zero = (out[30:0] == 31'd0);
  end
endmodule

module fp_alu_checker #(
  parameter int FAIL_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  fp_alu_checker_if.slave   bus,
  output logic [CNT_W-1:0]  vec_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              fail_lost,
  output logic              busy
);
  localparam int PW = (FAIL_DEPTH > 1) ? $clog2(FAIL_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [CNT_W-1:0] idx;
    logic [1:0]       op;
    logic [31:0]      out;
    logic             uo;
  } rec_t;

  logic             v1_q, v1_d;
  logic [31:0]      a_q, a_d, b_q, b_d, exp_q, exp_d;
  logic [1:0]       op_q, op_d;
  logic             exp_uo_q, exp_uo_d;
  logic [CNT_W-1:0] acc_q, acc_d, idx1_q, idx1_d;
  logic [CNT_W-1:0] vec_q, vec_d, fail_q, fail_d;
  logic             lost_q, lost_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  rec_t             mem_q [FAIL_DEPTH];
  rec_t             rec, head;
  logic [31:0]      alu_out;
  logic             alu_zero, alu_uo, mism, pop, push, full;

  FP_ALU u_alu (.para1(a_q), .para2(b_q), .ALU_op(op_q),
                .out(alu_out), .zero(alu_zero), .under_overflow(alu_uo));

  assign bus.in_ready = 1'b1;

  always_comb begin
    v1_d     = bus.in_valid;
    a_d      = bus.in_valid ? bus.in_para1   : a_q;
    b_d      = bus.in_valid ? bus.in_para2   : b_q;
    op_d     = bus.in_valid ? bus.in_op      : op_q;
    exp_d    = bus.in_valid ? bus.in_exp_out : exp_q;
    exp_uo_d = bus.in_valid ? bus.in_exp_uo  : exp_uo_q;
    idx1_d   = bus.in_valid ? acc_q          : idx1_q;
    acc_d    = acc_q + CNT_W'(bus.in_valid);

    mism   = v1_q && ((alu_out != exp_q) || (alu_uo != exp_uo_q));
    rec    = '{idx: idx1_q, op: op_q, out: alu_out, uo: alu_uo};
    vec_d  = vec_q  + CNT_W'(v1_q && (vec_q  != '1));
    fail_d = fail_q + CNT_W'(mism && (fail_q != '1));

    // A pop frees the slot a same-cycle push needs, so full+pop+push loses nothing.
    full     = (cnt_q == CW'(FAIL_DEPTH));
    pop      = bus.rd_ready && (cnt_q != '0);
    push     = mism && (!full || pop);
    lost_d   = lost_q | (mism && full && !pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      exp_q    <= '0;
      exp_uo_q <= 1'b0;
      idx1_q   <= '0;
      acc_q    <= '0;
      vec_q    <= '0;
      fail_q   <= '0;
      lost_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      v1_q     <= v1_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      exp_q    <= exp_d;
      exp_uo_q <= exp_uo_d;
      idx1_q   <= idx1_d;
      acc_q    <= acc_d;
      vec_q    <= vec_d;
      fail_q   <= fail_d;
      lost_q   <= lost_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk)
    if (!rst && push) mem_q[wr_ptr_q] <= rec;

  // Head fields read as zero while empty, so stale storage never shows after reset.
  assign head         = mem_q[rd_ptr_q];
  assign bus.rd_valid = (cnt_q != '0);
  assign bus.rd_index = bus.rd_valid ? head.idx : '0;
  assign bus.rd_op    = bus.rd_valid ? head.op  : '0;
  assign bus.rd_out   = bus.rd_valid ? head.out : '0;
  assign bus.rd_uo    = bus.rd_valid ? head.uo  : 1'b0;
  assign vec_count    = vec_q;
  assign fail_count   = fail_q;
  assign fail_lost    = lost_q;
  assign busy         = v1_q;
endmodule

// File: tb/tb_fp_alu_checker.sv
// Directed bench for fp_alu_checker (FAIL_DEPTH=4, CNT_W=4).
module tb_fp_alu_checker;
  localparam logic [31:0] ONE = 32'h3F800000, TWO = 32'h40000000, THREE = 32'h40400000;
  localparam logic [31:0] SIX = 32'h40C00000, BIG = 32'h7F000000, INF = 32'h7F800000;
  localparam logic [31:0] BAD = 32'h40000001;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] vec_count, fail_count;
  logic       fail_lost, busy;
  int         total = 0;
  int         bad = 0;

  fp_alu_checker_if #(.CNT_W(4)) bus ();

  fp_alu_checker #(.FAIL_DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .vec_count(vec_count),
    .fail_count(fail_count), .fail_lost(fail_lost), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic vec(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                     input logic [31:0] e, input logic u);
    bus.in_valid = 1'b1; bus.in_para1 = a; bus.in_para2 = b;
    bus.in_op = op; bus.in_exp_out = e; bus.in_exp_uo = u;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); bus.rd_ready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic pop1();
    bus.rd_ready = 1'b1; cyc(); bus.rd_ready = 1'b0;
  endtask

  initial begin
    vec(32'd0, 32'd0, 2'd0, 32'd0, 1'b0);
    do_reset();
    chk("rst_vec", vec_count, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst_rdv", bus.rd_valid, 0);
    chk("rst_lost", fail_lost, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_idx", bus.rd_index, 0);

    // single passing add
    vec(ONE, ONE, 2'd0, TWO, 1'b0); cyc(); idle();
    chk("pass_busy", busy, 1);
    chk("pass_vec_early", vec_count, 0);
    cyc();
    chk("pass_vec", vec_count, 1);
    chk("pass_fail", fail_count, 0);
    chk("pass_rdv", bus.rd_valid, 0);
    chk("pass_busy_off", busy, 0);

    // sub, mul, overflowing mul, all expected correctly
    vec(THREE, ONE, 2'd1, TWO, 1'b0); cyc();
    vec(TWO, THREE, 2'd2, SIX, 1'b0); cyc();
    vec(BIG, BIG, 2'd2, INF, 1'b1); cyc();
    idle(); cyc();
    chk("ops_vec", vec_count, 4);
    chk("ops_fail", fail_count, 0);
    chk("ops_rdv", bus.rd_valid, 0);

    // injected mismatch at index 5 of a back-to-back stream
    do_reset();
    for (int i = 0; i < 6; i++) begin
      vec(ONE, ONE, 2'd0, (i == 5) ? BAD : TWO, 1'b0);
      cyc();
    end
    idle();
    chk("mm_rdv_early", bus.rd_valid, 0);
    cyc();
    chk("mm_rdv", bus.rd_valid, 1);
    chk("mm_idx", bus.rd_index, 5);
    chk("mm_out", bus.rd_out, TWO);
    chk("mm_op", bus.rd_op, 0);
    chk("mm_uo", bus.rd_uo, 0);
    chk("mm_fail", fail_count, 1);
    chk("mm_vec", vec_count, 6);
    pop1();
    chk("mm_popped", bus.rd_valid, 0);

    // under_overflow mismatch only
    vec(BIG, BIG, 2'd2, INF, 1'b0); cyc(); idle(); cyc();
    chk("uo_rdv", bus.rd_valid, 1);
    chk("uo_uo", bus.rd_uo, 1);
    chk("uo_out", bus.rd_out, INF);
    chk("uo_op", bus.rd_op, 2);
    chk("uo_idx", bus.rd_index, 6);
    chk("uo_fail", fail_count, 2);
    pop1();

    // FIFO overflow: 6 failing vectors, nobody reading
    do_reset();
    for (int i = 0; i < 6; i++) begin
      vec(ONE, ONE, 2'd0, BAD, 1'b0); cyc();
    end
    idle(); cyc(); cyc();
    chk("ovf_fail", fail_count, 6);
    chk("ovf_lost", fail_lost, 1);
    chk("ovf_vec", vec_count, 6);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_rdv", bus.rd_valid, 1);
      chk("ovf_idx", bus.rd_index, 64'(i));
      pop1();
    end
    chk("ovf_empty", bus.rd_valid, 0);
    pop1();
    chk("ovf_pop_empty", bus.rd_valid, 0);
    chk("ovf_lost_sticky", fail_lost, 1);

    // full FIFO, simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vec(ONE, ONE, 2'd0, BAD, 1'b0); cyc();
    end
    idle(); cyc(); cyc();
    chk("full_rdv", bus.rd_valid, 1);
    chk("full_lost0", fail_lost, 0);
    for (int k = 0; k <= 10; k++) begin
      if (k < 6) vec(ONE, ONE, 2'd0, BAD, 1'b0);
      else idle();
      bus.rd_ready = (k >= 1);
      if (k >= 1) begin
        chk("pp_rdv", bus.rd_valid, 1);
        chk("pp_idx", bus.rd_index, 64'(k - 1));
      end
      cyc();
    end
    bus.rd_ready = 1'b0;
    chk("pp_empty", bus.rd_valid, 0);
    chk("pp_lost", fail_lost, 0);
    chk("pp_fail", fail_count, 10);

    // counter saturation and index wrap at CNT_W=4
    do_reset();
    for (int i = 0; i < 20; i++) begin
      vec(ONE, ONE, 2'd0, TWO, 1'b0); cyc();
    end
    idle(); cyc(); cyc();
    chk("sat_vec", vec_count, 15);
    chk("sat_fail", fail_count, 0);
    vec(ONE, ONE, 2'd0, BAD, 1'b0); cyc(); idle(); cyc();
    chk("wrap_idx", bus.rd_index, 4);
    chk("wrap_fail", fail_count, 1);
    chk("wrap_vec", vec_count, 15);

    // reset one cycle after an acceptance drops the in-flight vector
    vec(ONE, ONE, 2'd0, BAD, 1'b0); cyc();
    idle(); rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_vec", vec_count, 0);
    chk("mid_fail", fail_count, 0);
    chk("mid_rdv", bus.rd_valid, 0);
    chk("mid_lost", fail_lost, 0);
    chk("mid_busy", busy, 0);
    chk("mid_idx", bus.rd_index, 0);
    chk("mid_out", bus.rd_out, 0);
    cyc();
    chk("mid_vec_after", vec_count, 0);
    chk("mid_fail_after", fail_count, 0);

    // vector offered while rst is high is discarded
    rst = 1'b1; vec(ONE, ONE, 2'd0, BAD, 1'b0); cyc();
    rst = 1'b0; idle();
    chk("rstacc_busy", busy, 0);
    cyc(); cyc();
    chk("rstacc_vec", vec_count, 0);
    chk("rstacc_fail", fail_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_alu_checker.md
# fp_alu_checker

Self-checking hardware harness around the combinational `FP_ALU`, acting as the consuming end of the vector stream that feeds the ALU. It accepts (operand, operand, op, expected result) vectors over a valid/ready handshake and drives them through a registered `FP_ALU` instance. It compares `out` and `under_overflow` against the expected values, counts vectors and mismatches, and buffers mismatch records in a small FIFO for readout. It sits between a vector source (ROM, UART loader or bench) and a debug/readout port.

## Interface
Parameters:
- `FAIL_DEPTH`, 4: mismatch FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the vector counter, the fail counter and the record index.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: vector present.
- `in_ready` out 1: vector accepted when `in_valid && in_ready`.
- `in_para1` in 32: operand 1, IEEE-754 single.
- `in_para2` in 32: operand 2.
- `in_op` in 2: `ALU_op` passed to `FP_ALU`.
- `in_exp_out` in 32: expected `out`.
- `in_exp_uo` in 1: expected `under_overflow`.
- `rd_valid` out 1: mismatch record available at FIFO head.
- `rd_ready` in 1: pops the head when `rd_valid && rd_ready`.
- `rd_index` out CNT_W: vector index of the head record.
- `rd_op` out 2: op of the head record.
- `rd_out` out 32: actual `out` of the head record.
- `rd_uo` out 1: actual `under_overflow` of the head record.
- `vec_count` out CNT_W: vectors checked.
- `fail_count` out CNT_W: mismatches detected.
- `fail_lost` out 1: sticky; a mismatch was dropped because the FIFO was full.
- `busy` out 1: a vector is in stage S1 or S2.

## Operation
- `in_ready` is tied to 1; the harness never stalls the source.
- Stage S1 registers the accepted vector, its valid bit `v1`, and its index `idx1` = number of vectors accepted before it, counted mod 2^CNT_W.
- `FP_ALU` is driven from the S1 registers. Its outputs are compared against the S1 expected fields.
- Mismatch condition: `out != exp_out` or `under_overflow != exp_uo`. The `zero` output is not checked.
- Stage S2 acts at the edge after S1:
  - on `v1`, `vec_count` increments;
  - on `v1` with a mismatch, `fail_count` increments and the record {`idx1`, op, out, uo} is pushed into the FIFO.
- Both counters saturate at 2^CNT_W-1 and never wrap. `idx1` does wrap.
- FIFO behaviour:
  - push when full with no pop in the same cycle: the record is dropped and `fail_lost` is set (only `rst` clears it);
  - push and pop in the same cycle while full: both take effect, occupancy stays at FAIL_DEPTH, no loss;
  - pop when empty: ignored;
  - pointers wrap mod FAIL_DEPTH;
  - order is first-in first-out.
- `rd_*` outputs show the FIFO head and are stable while `rd_valid && !rd_ready`.
- `busy` = `v1` or a stage-S2 update pending.
- Reset values:
  - `in_ready`=1 (tied);
  - `v1`=0, `rd_valid`=0, `vec_count`=0, `fail_count`=0, `fail_lost`=0, `busy`=0;
  - `rd_index`/`rd_op`/`rd_out`/`rd_uo` = 0;
  - FIFO empty.
- A vector accepted in the same cycle `rst` is high is discarded.

## Timing
- A vector accepted on edge N is in S1 after edge N.
- Its compare result commits on edge N+1: counters update and any push is written.
- The record is visible on `rd_valid`/`rd_*` from cycle N+2 if the FIFO was empty. Latency is 2 cycles from acceptance.
- Throughput is one vector per cycle, sustained.
- A pop on edge M exposes the next record (or `rd_valid`=0) after edge M. Pop and push in the same cycle on an empty FIFO: no pop occurs, and the push lands.
- `rst` asserted mid-stream clears all state on the next edge. Vectors in flight are lost and not counted.

## Test plan
- Reset: hold `rst` 2 cycles, then check `vec_count`=0, `fail_count`=0, `rd_valid`=0, `fail_lost`=0, `busy`=0, `in_ready`=1.
- Pass vector: 0x3F800000 + 0x3F800000 using the add `ALU_op`, with exp 0x40000000, uo=0. Required: `vec_count`=1 two cycles after acceptance, `fail_count`=0, `rd_valid` stays 0.
- Injected mismatch: the same vector with exp 0x40000001 as vector index 5 in a back-to-back stream. Required: `rd_valid` high 2 cycles after acceptance, `rd_index`=5, `rd_out`=0x40000000, `fail_count`=1.
- FIFO overflow: FAIL_DEPTH+2 consecutive failing vectors with `rd_ready`=0. Required: `fail_count`=6 (for FAIL_DEPTH=4), `fail_lost`=1, and popping returns indices 0,1,2,3 in order, then `rd_valid`=0.
- Full push+pop: with the FIFO full, hold `rd_ready`=1 while failing vectors stream in. Required: `fail_lost` stays 0 and indices pop in sequence without gaps.
- Counter saturation and mid-stream reset: with CNT_W=4, send 20 passing vectors and require `vec_count`=15. Then assert `rst` one cycle after an acceptance and require all outputs at reset values with that vector not counted.
